// File: rtl/mc_stage_sequencer_if.sv
// Instruction-memory and debug-read bus between the stage sequencer (master)
// and the memory / debug host (slave).
interface mc_stage_sequencer_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              infer;
  logic [ADDR_W-1:0] infer_addr;
  logic [DATA_W-1:0] infer_data;

  modport master (
    output mem_addr,
    input  mem_rdata,
    input  infer,
    input  infer_addr,
    output infer_data
  );

  modport slave (
    input  mem_addr,
    output mem_rdata,
    output infer,
    output infer_addr,
    input  infer_data
  );
endinterface

// File: rtl/mc_stage_sequencer.sv
// Multi-cycle MIPS stage sequencer: owns PC/IR, dwell divider, single-step and debug read.
// Optional retired-instruction counter is enabled by defining SEQ_RETIRE_CNT_EN.
module mc_stage_sequencer #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DIV      = 1,
  parameter int unsigned PC_RESET = 0
) (
  input  logic                 fast_clk,
  input  logic                 rst,
  input  logic                 top_en,
  input  logic                 step_mode,
  input  logic                 step,
  mc_stage_sequencer_if.master bus,
  input  logic                 branch_taken,
  output logic [ADDR_W-1:0]    pc,
  output logic [DATA_W-1:0]    instr,
  output logic                 IF,
  output logic                 ID,
  output logic                 REG,
  output logic                 EX,
  output logic                 MEM,
  output logic                 WB,
  output logic                 JU,
  output logic                 BR,
  output logic                 SK,
  output logic [31:0]          retired
);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [3:0] {
    S_IDLE, S_IF, S_ID, S_REG, S_EX, S_MEM, S_WB, S_JU, S_BR, S_DBG, S_HALT
  } state_e;

  state_e            state_q;
  state_e            boundary_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] infer_data_q;
  logic [5:0]        opcode;
  logic              exec;
  logic              last;

  assign opcode = instr_q[31:26];
  assign exec   = !(state_q inside {S_IDLE, S_DBG, S_HALT});
  assign last   = (cnt_q == CNT_W'(DIV - 1));

  // Instruction-boundary decision, shared by IDLE, DBG exit and end of every instruction.
  always_comb begin
    boundary_d = S_IF;
    if (bus.infer)                boundary_d = S_DBG;
    else if (!top_en)             boundary_d = S_IDLE;
    else if (step_mode && !step)  boundary_d = S_IDLE;
  end

  always_ff @(posedge fast_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pc_q         <= ADDR_W'(PC_RESET);
      instr_q      <= '0;
      infer_data_q <= '0;
    end else begin
      // Every execution state leaves on its last dwell cycle, so the counter
      // restarts from zero on each state entry.
      cnt_q <= (exec && !last) ? cnt_q + 1'b1 : '0;
      if (state_q == S_DBG) infer_data_q <= bus.mem_rdata;

      case (state_q)
        S_IDLE: state_q <= boundary_d;
        S_DBG:  state_q <= boundary_d;
        S_HALT: state_q <= S_HALT;
        S_IF:   if (last) state_q <= S_ID;
        S_ID: if (last) begin
          instr_q <= bus.mem_rdata;
          pc_q    <= pc_q + 1'b1;
          state_q <= S_REG;
        end
        S_REG: if (last) begin
          if (opcode == OP_HALT)                    state_q <= S_HALT;
          else if (opcode inside {OP_J, OP_JAL})    state_q <= S_JU;
          else if (opcode inside {OP_BEQ, OP_BNE})  state_q <= S_BR;
          else                                      state_q <= S_EX;
        end
        S_EX: if (last) state_q <= (opcode inside {OP_LW, OP_SW}) ? S_MEM : S_WB;
        S_MEM: if (last) state_q <= (opcode == OP_LW) ? S_WB : boundary_d;
        S_WB: if (last) state_q <= boundary_d;
        S_JU: if (last) begin
          pc_q    <= instr_q[ADDR_W-1:0];
          state_q <= boundary_d;
        end
        S_BR: if (last) begin
          if (branch_taken) pc_q <= pc_q + instr_q[ADDR_W-1:0];
          state_q <= boundary_d;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_addr   = (state_q == S_DBG) ? bus.infer_addr : pc_q;
  assign bus.infer_data = infer_data_q;
  assign pc    = pc_q;
  assign instr = instr_q;

  assign IF  = (state_q == S_IF);
  assign ID  = (state_q == S_ID);
  assign REG = (state_q == S_REG);
  assign EX  = (state_q == S_EX);
  assign MEM = (state_q == S_MEM);
  assign WB  = (state_q == S_WB);
  assign JU  = (state_q == S_JU);
  assign BR  = (state_q == S_BR);
  assign SK  = !exec;

`ifdef SEQ_RETIRE_CNT_EN
  logic [31:0] retired_q;
  logic        retire_ev;

  assign retire_ev = last && ((state_q inside {S_WB, S_JU, S_BR}) ||
                              (state_q == S_MEM && opcode == OP_SW));

  always_ff @(posedge fast_clk) begin
    if (rst)            retired_q <= '0;
    else if (retire_ev) retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: doc/mc_stage_sequencer.md
# mc_stage_sequencer

Parametrised multi-cycle control sequencer for the MIPS core: the next generation of the fixed stage controller. It walks each instruction through one-hot stage flags (IF, ID, REG, EX, MEM, WB, JU, BR), owns the PC and instruction register, and supports a configurable stage-dwell divider, single-step mode and a debug memory read port (`infer`) that pauses execution at an instruction boundary. It sits between the instruction memory and the datapath/ALU, with `fast_clk` as its only clock.

## Interface
- `ADDR_W`, 10: word-address width of PC and memory.
- `DATA_W`, 32: instruction/data width. Must be at least 32.
- `DIV`, 1: `fast_clk` cycles each execution state is held, at least 1.
- `PC_RESET`, 0: PC value after reset.

- `fast_clk` in 1: the only clock. All logic is rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `top_en` in 1: run enable, sampled at instruction boundaries.
- `step_mode` in 1 / `step` in 1: single-step enable / one-cycle start pulse.
- `infer` in 1 / `infer_addr` in ADDR_W: debug read request / debug address.
- `infer_data` out DATA_W: registered debug read data.
- `mem_addr` out ADDR_W / `mem_rdata` in DATA_W: instruction memory with 1-cycle synchronous read.
- `branch_taken` in 1: datapath compare result, valid during BR.
- `pc` out ADDR_W / `instr` out DATA_W: registered PC and instruction.
- `IF`, `ID`, `REG`, `EX`, `MEM`, `WB`, `JU`, `BR` out 1 each: one-hot stage flags.
- `SK` out 1: high while the sequencer is not executing (IDLE, DBG or HALT).
- `retired` out 32: count of retired instructions.

## Operation
- States: IDLE, IF, ID, REG, EX, MEM, WB, JU, BR, DBG, HALT.
- Stage flags are decoded from the state register. Exactly one flag, or `SK`, is high in every cycle.
- **Boundary** is entry to IF from IDLE, WB, MEM, JU or BR. At a boundary the next state is chosen by priority:
  - `infer` = 1: go to DBG.
  - `top_en` = 0: go to IDLE.
  - `step_mode` = 1 and `step` = 0: go to IDLE.
  - Otherwise: go to IF.
- IDLE re-evaluates the boundary rule every cycle.
- Execution flow:
  - IF: `mem_addr` = `pc`. Next state is ID.
  - ID: `instr` <= `mem_rdata` and `pc` <= `pc`+1, both at the end of ID. Next state is REG.
  - REG decodes `instr[31:26]`:
    - 0x3F: go to HALT.
    - 0x02 or 0x03: go to JU.
    - 0x04 or 0x05: go to BR.
    - Anything else: go to EX.
  - EX: opcode 0x23 or 0x2B goes to MEM; anything else goes to WB.
  - MEM: opcode 0x23 goes to WB; 0x2B goes to the boundary.
  - WB goes to the boundary.
  - JU: `pc` <= `instr[ADDR_W-1:0]`, then boundary.
  - BR: if `branch_taken`, `pc` <= `pc` + `instr[ADDR_W-1:0]`, modulo 2^ADDR_W; otherwise `pc` is unchanged. Then boundary.
- PC arithmetic wraps modulo 2^ADDR_W. No overflow is flagged.
- DBG:
  - `mem_addr` = `infer_addr`.
  - `infer_data` <= `mem_rdata` every cycle.
  - `pc` and `instr` are frozen.
  - When `infer` falls, the boundary rule is re-evaluated with `infer` = 0.
- HALT is left only by `rst`.
- `infer_data` holds its last value outside DBG.
- In IDLE and HALT, `mem_addr` = `pc`.

## Timing
- Reset values:
  - State is IDLE.
  - `pc` = PC_RESET.
  - `instr` = 0, `infer_data` = 0, `retired` = 0.
  - All stage flags are 0 and `SK` = 1.
  - Dwell counter = 0.
- Each execution state lasts exactly DIV cycles. A mod-DIV counter gates transitions; it clears on entry to every state and on `rst`.
- IDLE, DBG and HALT evaluate every cycle, independent of DIV.
- Updates to `instr` and `pc` occur on the final dwell cycle of their state.
- Cycle counts with DIV=1:
  - R-type: 5 cycles (IF, ID, REG, EX, WB).
  - Load: 6 cycles.
  - Store: 5 cycles.
  - Jump or branch: 4 cycles.
- `infer_data` reflects `infer_addr` 2 cycles after the address is stable in DBG.
- `step` is sampled only at a boundary. A pulse mid-instruction is ignored, and one pulse executes exactly one instruction.
- `rst` overrides everything, including mid-instruction and in DBG or HALT.

## Configuration
- `SEQ_RETIRE_CNT_EN`
  - Defined: `retired` increments by 1 on every transition out of WB, MEM (store), JU or BR. It wraps at 2^32.
  - Undefined: the counter logic is removed and `retired` is tied to 0.

## Test plan
- Reset check: assert `rst` 2 cycles with `top_en` = 1. Required: `SK` = 1, `pc` = 0, `infer_data` = 0. Release `rst`: IF is high on the next cycle.
- R-type then load, DIV=1, mem[0]=0x00000020, mem[1]=0x8C000000. Required flags: IF, ID, REG, EX, WB, then IF, ID, REG, EX, MEM, WB. `pc` = 2 after the load's ID. `retired` = 2 with SEQ_RETIRE_CNT_EN.
- Taken branch, mem[0]=0x10000005, `branch_taken` = 1. Required: `pc` = 6 after BR. Taken branch with ADDR_W=10 at `pc` 1020 and offset 10 wraps to 7.
- Jump plus halt, mem[0]=0x08000010, mem[16]=0xFC000000. Required: `pc` = 16 after JU, then HALT with `SK` = 1 held for 50 cycles.
- Debug read: raise `infer` during EX. Required: execution finishes to WB, then DBG. With `infer_addr` = 17 and mem[17]=0xDEADBEEF, `infer_data` = 0xDEADBEEF 2 cycles later. Drop `infer`: IF resumes with `pc` unchanged.
- Step mode with DIV=3: each stage flag is held for 3 cycles. Holding `step_mode` = 1 keeps IDLE until a `step` pulse. One pulse retires one instruction, then returns to IDLE.
